instr_fetch_unit: RTL and testbench

//  Fetch stage of the 16-bit RISC core, directly upstream of the opcode decoder (control unit).

---
 rtl/instr_fetch_unit_pkg.sv | 19 +
 rtl/instr_fetch_unit_fetch_pc_reg.sv | 25 ++
 rtl/instr_fetch_unit.sv | 107 ++++++++++
 tb/tb_instr_fetch_unit.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the fetch stage: opcode constants, fetch FSM states
// and the default reset PC.
package instr_fetch_unit_pkg;

    localparam logic [3:0] OP_NOP = 4'b0000;
    localparam logic [3:0] OP_JAL = 4'b0111;
    localparam logic [3:0] OP_J   = 4'b1010;
    localparam logic [3:0] OP_JR  = 4'b1011;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_fetch_pc_reg.sv
// Program counter register: async reset to RESET_PC, redirect load has
// priority over the post-capture increment; wraps modulo 2^ADDR_W.
module fetch_pc_reg #(
    parameter int                 ADDR_W   = 16,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic              inc,
    output logic [ADDR_W-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_pc;
        end else if (inc) begin
            pc <= pc + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues one imem read at a time, holds the returned instruction
// with its PC on a valid/ready handshake, and discards fetches made stale by redirects.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                DATA_W   = 16,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [3:0]        opcode,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus1_o,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i
);

    fetch_state_e      state;
    fetch_state_e      state_nxt;
    logic              capture;
    logic [ADDR_W-1:0] pc;

    fetch_pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (redirect_i),
        .load_pc (redirect_pc_i),
        .inc     (capture),
        .pc      (pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        case (state)
            // A request issued in the same cycle as a redirect is still in flight.
            FETCH: state_nxt = redirect_i ? DRAIN : WAIT;
            WAIT: begin
                if (redirect_i) begin
                    state_nxt = imem_rvalid ? FETCH : DRAIN;
                end else if (imem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (redirect_i || instr_ready) begin
                    state_nxt = FETCH;
                end
            end
            // The outstanding read retiring ends the drain even if a new redirect
            // arrives with it; staying would wait for a response that never comes.
            DRAIN: begin
                if (imem_rvalid) begin
                    state_nxt = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
    end

    assign imem_req  = (state == FETCH) && rst_n;
    assign imem_addr = pc;
    assign opcode    = instr[DATA_W-1 -: 4];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_valid <= 1'b0;
            instr       <= '0;
            pc_o        <= RESET_PC;
            pc_plus1_o  <= RESET_PC + ADDR_W'(1);
        end else begin
            if (redirect_i) begin
                instr_valid <= 1'b0;
            end else if (capture) begin
                instr_valid <= 1'b1;
            end else if (state == HOLD && instr_ready) begin
                instr_valid <= 1'b0;
            end
            if (capture) begin
                instr      <= imem_rdata;
                pc_o       <= pc;
                pc_plus1_o <= pc + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: latency-programmable memory model,
// request-address and accepted-instruction scoreboards, plus a wrap-around instance.
module tb_instr_fetch_unit;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] word;
    } acc_t;

    typedef struct {
        int unsigned lat;
        logic [15:0] pc;
        logic [15:0] word;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, imem_req, imem_rvalid, instr_valid, instr_ready, redirect_i;
    logic [15:0] imem_addr, imem_rdata, instr, pc_o, pc_plus1_o, redirect_pc_i;
    logic [3:0]  opcode;

    logic        w_rst_n, w_imem_req, w_imem_rvalid, w_instr_valid, w_instr_ready;
    logic [15:0] w_imem_addr, w_imem_rdata, w_instr, w_pc_o, w_pc_plus1_o;
    logic [3:0]  w_opcode;

    instr_fetch_unit #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr(instr), .opcode(opcode), .pc_o(pc_o),
        .pc_plus1_o(pc_plus1_o), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i)
    );

    instr_fetch_unit #(.DATA_W(16), .ADDR_W(16), .RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .rst_n(w_rst_n), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata), .instr_valid(w_instr_valid),
        .instr_ready(w_instr_ready), .instr(w_instr), .opcode(w_opcode), .pc_o(w_pc_o),
        .pc_plus1_o(w_pc_plus1_o), .redirect_i(1'b0), .redirect_pc_i(16'h0000)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] mem [0:255];
    int unsigned lat;
    logic        auto_mem, a_rvalid, a_pending, m_rvalid, seen_req;
    logic [15:0] a_rdata, a_addr, m_rdata, seen_addr, exp_p1;
    int unsigned a_cnt;

    assign imem_rvalid = auto_mem ? a_rvalid : m_rvalid;
    assign imem_rdata  = auto_mem ? a_rdata  : m_rdata;

    logic [15:0] exp_addr [$];
    acc_t        exp_instr [$];
    int          acc_cyc [$];
    vec_t        vt [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tmo(input string name);
        checks++;
        failures++;
        $display("FAIL %s timeout waiting for DUT", name);
    endtask

    task automatic push_acc(input logic [15:0] pc, input logic [15:0] word);
        acc_t a;
        a.pc   = pc;
        a.word = word;
        exp_instr.push_back(a);
    endtask

    task automatic wait_accepts(input string name);
        int n = 0;
        while (exp_instr.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (exp_instr.size() != 0) tmo(name);
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!instr_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!instr_valid) tmo(name);
    endtask

    // Memory responder: a request seen in a cycle returns data lat cycles later.
    initial begin
        a_rvalid = 1'b0; a_rdata = '0; a_pending = 1'b0; a_cnt = 0; a_addr = '0;
        forever begin
            @(posedge clk); #1;
            a_rvalid = 1'b0;
            if (auto_mem) begin
                if (seen_req) begin
                    a_pending = 1'b1;
                    a_cnt     = lat;
                    a_addr    = seen_addr;
                end
                if (a_pending) begin
                    a_cnt--;
                    if (a_cnt == 0) begin
                        a_rvalid  = 1'b1;
                        a_rdata   = mem[a_addr[7:0]];
                        a_pending = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor on the falling edge: request addresses and accepted instructions.
    initial begin
        seen_req = 1'b0; seen_addr = '0; exp_p1 = '0;
        forever begin
            @(negedge clk);
            seen_req  = imem_req;
            seen_addr = imem_addr;
            if (imem_req) begin
                if (exp_addr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_req actual=%h required=none", imem_addr);
                end else begin
                    chk("req_addr", imem_addr, exp_addr.pop_front());
                end
                if (auto_mem) chk("one_outstanding", a_pending, 0);
            end
            if (instr_valid && instr_ready && !redirect_i) begin
                if (exp_instr.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_accept actual=%h required=none", instr);
                end else begin
                    acc_t e;
                    e = exp_instr.pop_front();
                    exp_p1 = e.pc + 16'd1;
                    chk("acc_instr", instr, e.word);
                    chk("acc_opcode", opcode, e.word[15:12]);
                    chk("acc_pc", pc_o, e.pc);
                    chk("acc_pc_plus1", pc_plus1_o, exp_p1);
                end
                acc_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; instr_ready = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0;
        auto_mem = 1'b1; lat = 1; m_rvalid = 1'b0; m_rdata = '0;
        w_rst_n = 1'b0; w_imem_rvalid = 1'b0; w_imem_rdata = '0; w_instr_ready = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h4000 + 16'(3 * i);
        mem[0] = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'h3789;
        vt[0] = '{1, 16'h0000, 16'h1123};
        vt[1] = '{1, 16'h0001, 16'h2456};
        vt[2] = '{1, 16'h0002, 16'h3789};
        vt[3] = '{2, 16'h0003, 16'h4009};
        vt[4] = '{3, 16'h0004, 16'h400C};
        vt[5] = '{1, 16'h0005, 16'h400F};

        repeat (2) @(posedge clk); #1;
        chk("rst_valid", instr_valid, 0);
        chk("rst_req", imem_req, 0);
        chk("rst_instr", instr, 16'h0000);
        chk("rst_opcode", opcode, 4'h0);
        chk("rst_pc", pc_o, 16'h0000);
        chk("rst_pc_plus1", pc_plus1_o, 16'h0001);
        chk("wrap_rst_pc_plus1", w_pc_plus1_o, 16'h0000);
        chk("wrap_rst_req", w_imem_req, 0);

        // Sequential stream with varied memory latency, ready held high.
        for (int i = 0; i < 6; i++) begin
            lat = vt[i].lat;
            exp_addr.push_back(vt[i].pc);
            push_acc(vt[i].pc, vt[i].word);
            if (i == 0) rst_n = 1'b1;
            wait_accepts("table");
        end
        if (acc_cyc.size() >= 3) begin
            chk("throughput_1", acc_cyc[1] - acc_cyc[0], 3);
            chk("throughput_2", acc_cyc[2] - acc_cyc[1], 3);
        end else begin
            tmo("throughput");
        end

        // Backpressure: outputs held, no request while waiting for ready.
        lat = 1;
        instr_ready = 1'b0;
        exp_addr.push_back(16'h0006);
        wait_valid("bp_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", instr_valid, 1);
            chk("bp_instr", instr, 16'h4012);
            chk("bp_pc", pc_o, 16'h0006);
            chk("bp_no_req", imem_req, 0);
        end
        @(posedge clk); #1;
        push_acc(16'h0006, 16'h4012);
        instr_ready = 1'b1;
        wait_accepts("bp_accept");

        // Redirect in HOLD with ready high: held instruction is dropped.
        instr_ready = 1'b0;
        exp_addr.push_back(16'h0007);
        wait_valid("hold_valid");
        chk("hold_instr", instr, 16'h4015);
        instr_ready = 1'b1;
        redirect_i = 1'b1;
        redirect_pc_i = 16'h0040;
        exp_addr.push_back(16'h0040);
        push_acc(16'h0040, 16'h40C0);
        @(posedge clk); #1;
        redirect_i = 1'b0;
        chk("redir_hold_drop", instr_valid, 0);
        wait_accepts("redir_hold");

        // Redirect in WAIT with latency 4: stale word must be drained.
        lat = 4;
        exp_addr.push_back(16'h0041);
        @(posedge clk); #1;
        redirect_i = 1'b1;
        redirect_pc_i = 16'h0080;
        exp_addr.push_back(16'h0080);
        push_acc(16'h0080, 16'h4180);
        @(posedge clk); #1;
        redirect_i = 1'b0;
        lat = 1;
        chk("drain_no_valid", instr_valid, 0);
        wait_accepts("redir_wait");

        // Reset during WAIT, then a late response while fetching from RESET_PC.
        auto_mem = 1'b0;
        exp_addr.push_back(16'h0081);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_req", imem_req, 0);
        chk("mid_rst_instr", instr, 16'h0000);
        chk("mid_rst_pc", pc_o, 16'h0000);
        chk("mid_rst_pc_plus1", pc_plus1_o, 16'h0001);
        @(posedge clk); #1;
        exp_addr.push_back(16'h0000);
        rst_n = 1'b1;
        m_rvalid = 1'b1;
        m_rdata = 16'hDEAD;
        @(posedge clk); #1;
        m_rdata = 16'h1123;
        push_acc(16'h0000, 16'h1123);
        instr_ready = 1'b1;
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        wait_accepts("post_rst");
        instr_ready = 1'b0;
        exp_addr.push_back(16'h0001);
        repeat (3) @(posedge clk); #1;

        // PC wrap on a RESET_PC=16'hFFFF instance.
        w_rst_n = 1'b1;
        @(negedge clk);
        chk("wrap_req", w_imem_req, 1);
        chk("wrap_addr", w_imem_addr, 16'hFFFF);
        @(posedge clk); #1;
        w_imem_rvalid = 1'b1;
        w_imem_rdata = 16'h7123;
        @(posedge clk); #1;
        w_imem_rvalid = 1'b0;
        chk("wrap_valid", w_instr_valid, 1);
        chk("wrap_instr", w_instr, 16'h7123);
        chk("wrap_opcode", w_opcode, 4'h7);
        chk("wrap_pc", w_pc_o, 16'hFFFF);
        chk("wrap_pc_plus1", w_pc_plus1_o, 16'h0000);
        w_instr_ready = 1'b1;
        @(posedge clk); #1;
        w_instr_ready = 1'b0;
        @(negedge clk);
        chk("wrap_next_req", w_imem_req, 1);
        chk("wrap_next_addr", w_imem_addr, 16'h0000);

        chk("addr_queue_drained", exp_addr.size(), 0);
        chk("instr_queue_drained", exp_instr.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
